al_entry_controller: RTL and testbench

Parametrised keypad-entry controller for the alarm clock: next generation of the top alarm controller. It consumes the keypad scancode stream and drives the digit shift register, the time and alarm load strobes and the alarm display select. Over the single-alarm controller it adds:

- configurable digit count and timeout, with the timeout restarted by each digit;
- multiple alarm slots;
- a clear key and switch-driven commits;
- a strobed key interface.

It sits between the keypad decoder and the key/alarm/time registers.

---
 rtl/al_entry_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_al_entry_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/al_entry_controller.sv
// al_entry_controller
// Keypad-entry controller for the alarm clock. It consumes strobed keypad
// scancodes and drives the digit shift register, the alarm and time load
// strobes, and the alarm display select. It supports configurable digit
// count, an idle timeout that restarts on each digit, several alarm slots,
// a clear key, and switch-driven commits.
//
// Ports:
//   clk256        in   256 Hz system clock
//   reset         in   synchronous, active-high reset
//   one_second    in   one-cycle pulse per second
//   key[7:0]      in   scancode, qualified by key_valid
//   key_valid     in   one-cycle key strobe
//   set_alarm     in   level switch, rising edge commits entry to the alarm
//   set_time      in   level switch, rising edge commits entry to the time
//   shift         out  pulse per accepted digit
//   load_alarm    out  commit pulse for alarm slot alarm_sel
//   load_new_time out  commit pulse for the current time
//   show_alarm    out  level, display shows alarm slot alarm_sel
//   clear_entry   out  pulse, key register must zero
//   entry_active  out  high while an entry is in progress
//   alarm_sel     out  selected alarm slot
//   digit_count   out  digits accepted in the current entry
module al_entry_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int TIMEOUT_SECS = 10,
    parameter int NUM_ALARMS   = 1,
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clk256,
    input  logic             reset,
    input  logic             one_second,
    input  logic [7:0]       key,
    input  logic             key_valid,
    input  logic             set_alarm,
    input  logic             set_time,
    output logic             shift,
    output logic             load_alarm,
    output logic             load_new_time,
    output logic             show_alarm,
    output logic             clear_entry,
    output logic             entry_active,
    output logic [SEL_W-1:0] alarm_sel,
    output logic [CNT_W-1:0] digit_count
);

    // PS/2 set-2 keypad scancodes
    localparam logic [7:0] KP_0            = 8'h70;
    localparam logic [7:0] KP_1            = 8'h69;
    localparam logic [7:0] KP_2            = 8'h72;
    localparam logic [7:0] KP_3            = 8'h7A;
    localparam logic [7:0] KP_4            = 8'h6B;
    localparam logic [7:0] KP_5            = 8'h73;
    localparam logic [7:0] KP_6            = 8'h74;
    localparam logic [7:0] KP_7            = 8'h6C;
    localparam logic [7:0] KP_8            = 8'h75;
    localparam logic [7:0] KP_9            = 8'h7D;
    localparam logic [7:0] KP_STAR         = 8'h7C;
    localparam logic [7:0] KP_MINUS        = 8'h7B;
    localparam logic [7:0] KP_PLUS         = 8'h79;
    localparam logic [7:0] KP_DOT          = 8'h71;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [7:0]       TMR_LOAD = 8'(TIMEOUT_SECS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ALARMS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       timer_q, timer_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pend_q, pend_d;
    logic             set_alarm_q, set_time_q;
    logic             shift_q, shift_d;
    logic             load_alarm_q, load_alarm_d;
    logic             load_time_q, load_time_d;
    logic             show_q, show_d;
    logic             clear_q, clear_d;
    logic             active_q, active_d;

    logic key_act, is_digit, full, alarm_rise, time_rise, key_cmd;
    logic do_alarm, do_time;

    always_comb begin
        is_digit = 1'b0;
        case (key)
            KP_0, KP_1, KP_2, KP_3, KP_4,
            KP_5, KP_6, KP_7, KP_8, KP_9: is_digit = 1'b1;
            default:                      is_digit = 1'b0;
        endcase
    end

    assign alarm_rise = set_alarm & ~set_alarm_q;
    assign time_rise  = set_time & ~set_time_q;
    assign full       = (cnt_q == CNT_FULL);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        sel_d        = sel_q;
        pend_d       = pend_q;
        shift_d      = 1'b0;
        load_alarm_d = 1'b0;
        load_time_d  = 1'b0;
        clear_d      = 1'b0;
        key_act      = 1'b0;

        // The code following a release prefix is swallowed; its only effect
        // is ending the alarm display.
        if (key_valid) begin
            if (pend_q) begin
                pend_d = 1'b0;
                if (state_q == ST_SHOW) state_d = ST_IDLE;
            end else if (key == KP_KEY_RELEASED) begin
                pend_d = 1'b1;
            end else begin
                key_act = 1'b1;
            end
        end

        // A commit key in this cycle masks any switch edge; set_alarm edge
        // beats set_time edge.
        key_cmd  = key_act & ((key == KP_STAR) | (key == KP_MINUS) | (key == KP_DOT));
        do_alarm = full & ((key_act & (key == KP_STAR)) | (~key_cmd & alarm_rise));
        do_time  = full & ((key_act & (key == KP_MINUS)) |
                           (~key_cmd & ~alarm_rise & time_rise));

        case (state_q)
            ST_IDLE: begin
                if (key_act & is_digit) begin
                    shift_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                    timer_d = TMR_LOAD;
                    state_d = ST_ENTRY;
                end else if (key_act & (key == KP_STAR)) begin
                    state_d = ST_SHOW;
                end else if (key_act & (key == KP_PLUS)) begin
                    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                end
            end
            ST_ENTRY: begin
                if (do_alarm | do_time) begin
                    load_alarm_d = do_alarm;
                    load_time_d  = do_time;
                    cnt_d        = '0;
                    timer_d      = '0;
                    state_d      = ST_IDLE;
                end else if (key_act & (key == KP_DOT)) begin
                    clear_d = 1'b1;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (key_act & is_digit & ~full) begin
                    shift_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = TMR_LOAD;
                end else if (one_second & ~key_valid & (timer_q != 8'd0)) begin
                    // Any key strobe in this cycle drops the tick.
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        clear_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;  // ST_SHOW: left only via the swallowed release code
        endcase

        show_d   = (state_d == ST_SHOW);
        active_d = (state_d == ST_ENTRY);
    end

    always_ff @(posedge clk256) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            timer_q      <= '0;
            sel_q        <= '0;
            pend_q       <= 1'b0;
            set_alarm_q  <= 1'b0;
            set_time_q   <= 1'b0;
            shift_q      <= 1'b0;
            load_alarm_q <= 1'b0;
            load_time_q  <= 1'b0;
            show_q       <= 1'b0;
            clear_q      <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            pend_q       <= pend_d;
            set_alarm_q  <= set_alarm;
            set_time_q   <= set_time;
            shift_q      <= shift_d;
            load_alarm_q <= load_alarm_d;
            load_time_q  <= load_time_d;
            show_q       <= show_d;
            clear_q      <= clear_d;
            active_q     <= active_d;
        end
    end

    assign shift         = shift_q;
    assign load_alarm    = load_alarm_q;
    assign load_new_time = load_time_q;
    assign show_alarm    = show_q;
    assign clear_entry   = clear_q;
    assign entry_active  = active_q;
    assign alarm_sel     = sel_q;
    assign digit_count   = cnt_q;

endmodule

// File: tb/tb_al_entry_controller.sv
// Bench for al_entry_controller (NUM_DIGITS=4, TIMEOUT_SECS=10, NUM_ALARMS=3):
// directed scenarios against constants, then random traffic against a
// behavioural model of the keypad entry rules.
module tb_al_entry_controller;

    localparam int ND = 4;
    localparam int TO = 10;
    localparam int NA = 3;

    localparam logic [7:0] KP_0 = 8'h70, KP_1 = 8'h69, KP_2 = 8'h72, KP_3 = 8'h7A;
    localparam logic [7:0] KP_4 = 8'h6B, KP_5 = 8'h73, KP_6 = 8'h74, KP_7 = 8'h6C;
    localparam logic [7:0] KP_8 = 8'h75, KP_9 = 8'h7D;
    localparam logic [7:0] KP_STAR = 8'h7C, KP_MINUS = 8'h7B, KP_PLUS = 8'h79;
    localparam logic [7:0] KP_DOT = 8'h71, KP_REL = 8'hF0;

    logic       clk256 = 1'b0;
    logic       reset, one_second, key_valid, set_alarm, set_time;
    logic [7:0] key;
    logic       shift, load_alarm, load_new_time, show_alarm, clear_entry, entry_active;
    logic [1:0] alarm_sel;
    logic [2:0] digit_count;

    int total = 0;
    int bad   = 0;

    // model state: mode 0=idle, 1=entry, 2=showing alarm
    int m_mode, m_cnt, m_timer, m_sel;
    bit m_pend, m_pa, m_pt;
    bit e_shift, e_la, e_lt, e_clr;
    bit cur_sa, cur_st;

    al_entry_controller #(.NUM_DIGITS(ND), .TIMEOUT_SECS(TO), .NUM_ALARMS(NA)) dut (
        .clk256(clk256), .reset(reset), .one_second(one_second), .key(key),
        .key_valid(key_valid), .set_alarm(set_alarm), .set_time(set_time),
        .shift(shift), .load_alarm(load_alarm), .load_new_time(load_new_time),
        .show_alarm(show_alarm), .clear_entry(clear_entry), .entry_active(entry_active),
        .alarm_sel(alarm_sel), .digit_count(digit_count)
    );

    always #5 clk256 = ~clk256;

    function automatic bit is_dig(input logic [7:0] k);
        return k inside {KP_0, KP_1, KP_2, KP_3, KP_4, KP_5, KP_6, KP_7, KP_8, KP_9};
    endfunction

    task automatic model(input bit kv, input logic [7:0] k, input bit os,
                         input bit sa, input bit st, input bit rst);
        bit ar, tr, act, kc;
        e_shift = 0; e_la = 0; e_lt = 0; e_clr = 0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_timer = 0; m_sel = 0;
            m_pend = 0; m_pa = 0; m_pt = 0;
            return;
        end
        ar = sa && !m_pa; tr = st && !m_pt;
        m_pa = sa; m_pt = st;
        act = 0;
        if (kv) begin
            if (m_pend) begin
                m_pend = 0;
                if (m_mode == 2) m_mode = 0;
            end else if (k == KP_REL) m_pend = 1;
            else act = 1;
        end
        if (m_mode == 0) begin
            if (act && is_dig(k)) begin
                e_shift = 1; m_cnt = 1; m_timer = TO; m_mode = 1;
            end else if (act && k == KP_STAR) m_mode = 2;
            else if (act && k == KP_PLUS) m_sel = (m_sel + 1) % NA;
        end else if (m_mode == 1) begin
            kc = act && (k == KP_STAR || k == KP_MINUS || k == KP_DOT);
            if (m_cnt == ND && ((act && k == KP_STAR) || (!kc && ar))) begin
                e_la = 1; m_cnt = 0; m_mode = 0;
            end else if (m_cnt == ND && ((act && k == KP_MINUS) || (!kc && tr))) begin
                e_lt = 1; m_cnt = 0; m_mode = 0;
            end else if (act && k == KP_DOT) begin
                e_clr = 1; m_cnt = 0; m_mode = 0;
            end else if (act && is_dig(k)) begin
                if (m_cnt < ND) begin
                    e_shift = 1; m_cnt++; m_timer = TO;
                end
            end else if (os && !kv && m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin
                    e_clr = 1; m_cnt = 0; m_mode = 0;
                end
            end
        end
    endtask

    task automatic step(input bit kv, input logic [7:0] k, input bit os,
                        input bit sa, input bit st, input bit rst);
        key_valid = kv; key = k; one_second = os;
        set_alarm = sa; set_time = st; reset = rst;
        cur_sa = sa; cur_st = st;
        model(kv, k, os, sa, st, rst);
        @(posedge clk256);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        step(1, k, 0, cur_sa, cur_st, 0);
    endtask

    task automatic brk(input logic [7:0] k);
        step(1, KP_REL, 0, cur_sa, cur_st, 0);
        step(1, k, 0, cur_sa, cur_st, 0);
    endtask

    task automatic idle();
        step(0, 8'h00, 0, cur_sa, cur_st, 0);
    endtask

    task automatic tick();
        step(0, 8'h00, 1, cur_sa, cur_st, 0);
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);
        total++;
        if ({shift, load_alarm, load_new_time, show_alarm, clear_entry, entry_active,
             alarm_sel, digit_count} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {shift, load_alarm, load_new_time,
                     show_alarm, clear_entry, entry_active, alarm_sel, digit_count});
        end
        idle();
    endtask

    task automatic test_alarm_commit();
        logic [7:0] seq [4] = '{KP_1, KP_2, KP_3, KP_0};
        for (int i = 0; i < 4; i++) begin
            press(seq[i]);
            total++;
            if (shift !== 1'b1 || digit_count !== 3'(i + 1)) begin
                bad++;
                $display("FAIL digit_shift[%0d] got shift=%b cnt=%0d exp shift=1 cnt=%0d",
                         i, shift, digit_count, i + 1);
            end
            brk(seq[i]);
        end
        press(KP_STAR);
        total++;
        if (load_alarm !== 1'b1 || digit_count !== 3'd0 || alarm_sel !== 2'd0 ||
            entry_active !== 1'b0) begin
            bad++;
            $display("FAIL star_commit got la=%b cnt=%0d sel=%0d act=%b exp la=1 cnt=0 sel=0 act=0",
                     load_alarm, digit_count, alarm_sel, entry_active);
        end
        brk(KP_STAR);
        total++;
        if (load_alarm !== 1'b0 || show_alarm !== 1'b0) begin
            bad++;
            $display("FAIL commit_one_cycle got la=%b show=%b exp 0 0", load_alarm, show_alarm);
        end
    endtask

    task automatic test_slots_and_show();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            press(KP_PLUS);
            total++;
            if (alarm_sel !== exp_sel[i]) begin
                bad++;
                $display("FAIL slot_cycle[%0d] got=%0d exp=%0d", i, alarm_sel, exp_sel[i]);
            end
            brk(KP_PLUS);
        end
        press(KP_STAR);
        press(KP_STAR);
        press(KP_5);
        step(1, KP_REL, 0, cur_sa, cur_st, 0);
        total++;
        if (show_alarm !== 1'b1 || shift !== 1'b0) begin
            bad++;
            $display("FAIL show_held got show=%b shift=%b exp show=1 shift=0", show_alarm, shift);
        end
        press(KP_STAR);
        total++;
        if (show_alarm !== 1'b0 || alarm_sel !== 2'd1) begin
            bad++;
            $display("FAIL show_release got show=%b sel=%0d exp show=0 sel=1", show_alarm, alarm_sel);
        end
    endtask

    task automatic test_partial_commit();
        press(KP_4); brk(KP_4);
        press(KP_6); brk(KP_6);
        press(KP_MINUS);
        total++;
        if (load_new_time !== 1'b0 || entry_active !== 1'b1 || digit_count !== 3'd2) begin
            bad++;
            $display("FAIL short_commit got lt=%b act=%b cnt=%0d exp lt=0 act=1 cnt=2",
                     load_new_time, entry_active, digit_count);
        end
        brk(KP_MINUS);
        press(KP_7); brk(KP_7);
        press(KP_8); brk(KP_8);
        press(KP_9);
        total++;
        if (shift !== 1'b0 || digit_count !== 3'd4) begin
            bad++;
            $display("FAIL fifth_digit got shift=%b cnt=%0d exp shift=0 cnt=4", shift, digit_count);
        end
        brk(KP_9);
        step(0, 8'h00, 0, 0, 1, 0);
        total++;
        if (load_new_time !== 1'b1 || load_alarm !== 1'b0 || entry_active !== 1'b0) begin
            bad++;
            $display("FAIL set_time_rise got lt=%b la=%b act=%b exp lt=1 la=0 act=0",
                     load_new_time, load_alarm, entry_active);
        end
        step(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        press(KP_1); brk(KP_1);
        for (int i = 0; i < 9; i++) begin tick(); idle(); end
        total++;
        if (entry_active !== 1'b1 || clear_entry !== 1'b0) begin
            bad++;
            $display("FAIL before_timeout got act=%b clr=%b exp act=1 clr=0", entry_active, clear_entry);
        end
        tick();
        total++;
        if (clear_entry !== 1'b1 || entry_active !== 1'b0 || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL timeout got clr=%b act=%b cnt=%0d exp clr=1 act=0 cnt=0",
                     clear_entry, entry_active, digit_count);
        end
        idle();
        press(KP_2); brk(KP_2);
        for (int i = 0; i < 8; i++) begin tick(); idle(); end
        step(1, KP_3, 1, cur_sa, cur_st, 0);
        brk(KP_3);
        for (int i = 0; i < 9; i++) begin tick(); idle(); end
        total++;
        if (entry_active !== 1'b1 || digit_count !== 3'd2) begin
            bad++;
            $display("FAIL reload_timeout got act=%b cnt=%0d exp act=1 cnt=2", entry_active, digit_count);
        end
        tick();
        total++;
        if (clear_entry !== 1'b1 || entry_active !== 1'b0) begin
            bad++;
            $display("FAIL reload_expire got clr=%b act=%b exp clr=1 act=0", clear_entry, entry_active);
        end
        idle();
    endtask

    task automatic test_same_cycle_and_reset();
        press(KP_1);
        step(1, KP_5, 1, cur_sa, cur_st, 0);
        total++;
        if (shift !== 1'b1 || digit_count !== 3'd2) begin
            bad++;
            $display("FAIL key_beats_tick got shift=%b cnt=%0d exp shift=1 cnt=2", shift, digit_count);
        end
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (entry_active !== 1'b1) begin
            bad++;
            $display("FAIL tick_dropped got act=%b exp act=1", entry_active);
        end
        tick();
        total++;
        if (clear_entry !== 1'b1) begin
            bad++;
            $display("FAIL tick_dropped_expire got clr=%b exp 1", clear_entry);
        end
        press(KP_PLUS);
        press(KP_6);
        step(0, 8'h00, 0, 0, 0, 1);
        total++;
        if ({shift, load_alarm, load_new_time, show_alarm, clear_entry, entry_active,
             alarm_sel, digit_count} !== 11'd0) begin
            bad++;
            $display("FAIL mid_entry_reset got=%b exp=0", {shift, load_alarm, load_new_time,
                     show_alarm, clear_entry, entry_active, alarm_sel, digit_count});
        end
        idle();
    endtask

    task automatic test_dot();
        press(KP_7); press(KP_8); press(KP_9);
        press(KP_DOT);
        total++;
        if (clear_entry !== 1'b1 || digit_count !== 3'd0 || entry_active !== 1'b0) begin
            bad++;
            $display("FAIL dot_clear got clr=%b cnt=%0d act=%b exp clr=1 cnt=0 act=0",
                     clear_entry, digit_count, entry_active);
        end
        brk(KP_STAR);
        total++;
        if (show_alarm !== 1'b0 || clear_entry !== 1'b0) begin
            bad++;
            $display("FAIL release_star got show=%b clr=%b exp 0 0", show_alarm, clear_entry);
        end
        idle();
    endtask

    task automatic test_random();
        logic [7:0] pool [8] = '{KP_0, KP_3, KP_9, KP_STAR, KP_MINUS, KP_PLUS, KP_DOT, KP_REL};
        logic [10:0] exp_v, got_v;
        int errs = 0;
        for (int i = 0; i < 4000; i++) begin
            bit kv, os, sa, st, rst;
            logic [7:0] k;
            kv  = ($urandom_range(0, 99) < 35);
            k   = pool[$urandom_range(0, 7)];
            os  = ($urandom_range(0, 99) < 15);
            sa  = ($urandom_range(0, 99) < 4) ? ~cur_sa : cur_sa;
            st  = ($urandom_range(0, 99) < 4) ? ~cur_st : cur_st;
            rst = ($urandom_range(0, 499) == 0);
            step(kv, k, os, sa, st, rst);
            exp_v = {e_shift, e_la, e_lt, (m_mode == 2), e_clr, (m_mode == 1),
                     2'(m_sel), 3'(m_cnt)};
            got_v = {shift, load_alarm, load_new_time, show_alarm, clear_entry, entry_active,
                     alarm_sel, digit_count};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d] got=%b exp=%b", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        cur_sa = 0; cur_st = 0;
        key_valid = 0; key = 8'h00; one_second = 0;
        set_alarm = 0; set_time = 0; reset = 1;
        test_reset();
        test_alarm_commit();
        test_slots_and_show();
        test_partial_commit();
        test_timeout();
        test_same_cycle_and_reset();
        test_dot();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
